// File: rtl/rob_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rob_ctrl_if
//  Description : Bundles the issue-stage allocation port, the common data
//                bus completion port and the in-order commit port of the
//                reorder-buffer controller. Occupancy status rides along.
//                master = issue/CDB/register-bank side, slave = ROB.
//  Revision    : 1.0  initial release
// ============================================================================
interface rob_ctrl_if #(
    parameter int IDX_W  = 3,
    parameter int DATA_W = 16
);
    // Allocation from the issue stage
    logic              alloc_req;
    logic [3:0]        alloc_func;
    logic [3:0]        alloc_rd;
    logic              alloc_gnt;
    logic [IDX_W-1:0]  alloc_idx;

    // Occupancy status
    logic              full;
    logic              empty;
    logic [IDX_W:0]    count;

    // Completion from the common data bus
    logic              cdb_valid;
    logic [IDX_W-1:0]  cdb_idx;
    logic [DATA_W-1:0] cdb_value;

    // In-order commit to the register bank
    logic              commit_valid;
    logic              commit_ready;
    logic [IDX_W-1:0]  commit_idx;
    logic [3:0]        commit_rd;
    logic [3:0]        commit_func;
    logic [DATA_W-1:0] commit_value;

    modport master (
        output alloc_req, alloc_func, alloc_rd,
        input  alloc_gnt, alloc_idx,
        input  full, empty, count,
        output cdb_valid, cdb_idx, cdb_value,
        input  commit_valid,
        output commit_ready,
        input  commit_idx, commit_rd, commit_func, commit_value
    );

    modport slave (
        input  alloc_req, alloc_func, alloc_rd,
        output alloc_gnt, alloc_idx,
        output full, empty, count,
        input  cdb_valid, cdb_idx, cdb_value,
        output commit_valid,
        input  commit_ready,
        output commit_idx, commit_rd, commit_func, commit_value
    );
endinterface
`default_nettype wire

// File: rtl/rob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rob_ctrl
//  Description : Reorder-buffer allocation / completion / commit controller.
//                Entries are allocated at the tail, completed out of order
//                from the CDB and retired in order from the head. An explicit
//                occupancy count disambiguates full from empty.
//                Optional macro ROB_FLUSH_EN adds a 'flush' input that clears
//                every entry and both pointers at the next clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module rob_ctrl #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 16
) (
    input  logic        clk1,
    input  logic        rst,
`ifdef ROB_FLUSH_EN
    input  logic        flush,
`endif
    rob_ctrl_if.slave   bus
);

    localparam logic [IDX_W:0]   c_DEPTH   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   c_CNT_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] c_PTR_ONE = IDX_W'(1);

    // Per-entry state
    logic              r_valid [DEPTH];
    logic              r_done  [DEPTH];
    logic [3:0]        r_func  [DEPTH];
    logic [3:0]        r_rd    [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];

    // Pointers and occupancy
    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [IDX_W:0]    r_count;

    logic              w_flush;
    logic              w_full;
    logic              w_gnt;
    logic              w_commit_valid;
    logic              w_fire;
    logic              w_cdb_hit;

`ifdef ROB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // The grant only looks at the registered count, so a commit in the same
    // cycle never opens a slot for that cycle's allocation. Reset also masks
    // it so the grant reads 0 while rst is held.
    assign w_full         = (r_count == c_DEPTH);
    assign w_gnt          = bus.alloc_req & ~w_full & ~w_flush & ~rst;
    assign w_commit_valid = r_valid[r_head] & r_done[r_head];
    assign w_fire         = w_commit_valid & bus.commit_ready;

    // Completion only lands on a live, not-yet-done entry; an entry being
    // allocated this cycle is still invalid and therefore ignored.
    assign w_cdb_hit      = bus.cdb_valid & r_valid[bus.cdb_idx] & ~r_done[bus.cdb_idx];

    assign bus.alloc_gnt    = w_gnt;
    assign bus.alloc_idx    = r_tail;
    assign bus.full         = w_full;
    assign bus.empty        = (r_count == '0);
    assign bus.count        = r_count;
    assign bus.commit_valid = w_commit_valid;
    assign bus.commit_idx   = r_head;
    assign bus.commit_rd    = r_rd[r_head];
    assign bus.commit_func  = r_func[r_head];
    assign bus.commit_value = r_value[r_head];

    // Head/tail pointers and occupancy count; wrap by modulo arithmetic only
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_gnt) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_fire) begin
                r_head <= r_head + c_PTR_ONE;
            end
            case ({w_gnt, w_fire})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: commit retires the head, CDB completes, allocation fills
    // the tail. The three never target the same live entry in one cycle.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i]  <= 1'b0;
                r_func[i]  <= '0;
                r_rd[i]    <= '0;
                r_value[i] <= '0;
            end
        end else if (w_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i]  <= 1'b0;
            end
        end else begin
            if (w_fire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
            end
            if (w_cdb_hit) begin
                r_done[bus.cdb_idx]  <= 1'b1;
                r_value[bus.cdb_idx] <= bus.cdb_value;
            end
            if (w_gnt) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_func[r_tail]  <= bus.alloc_func;
                r_rd[r_tail]    <= bus.alloc_rd;
                r_value[r_tail] <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_ctrl
//  Description : Directed self-checking bench for rob_ctrl with hand-computed
//                expected values. Exercises reset, fill to full, out-of-order
//                completion with in-order commit, full-with-commit, ignored
//                CDB writes, asynchronous mid-run reset and (with
//                ROB_FLUSH_EN) flush.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rob_ctrl;

    logic clk1;
    logic rst;
`ifdef ROB_FLUSH_EN
    logic flush;
`endif

    int n_checks;
    int n_errors;

    rob_ctrl_if #(.IDX_W(3), .DATA_W(16)) bus ();

    rob_ctrl #(
        .DEPTH  (8),
        .IDX_W  (3),
        .DATA_W (16)
    ) u_dut (
        .clk1  (clk1),
        .rst   (rst),
`ifdef ROB_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus.slave)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_req    = 1'b0;
        bus.alloc_func   = 4'h0;
        bus.alloc_rd     = 4'h0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_idx      = 3'd0;
        bus.cdb_value    = 16'h0;
        bus.commit_ready = 1'b0;
`ifdef ROB_FLUSH_EN
        flush            = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic alloc_one(input logic [3:0] func, input logic [3:0] rd);
        bus.alloc_req  = 1'b1;
        bus.alloc_func = func;
        bus.alloc_rd   = rd;
        step();
        bus.alloc_req  = 1'b0;
    endtask

    task automatic cdb_one(input logic [2:0] idx, input logic [15:0] val);
        bus.cdb_valid = 1'b1;
        bus.cdb_idx   = idx;
        bus.cdb_value = val;
        step();
        bus.cdb_valid = 1'b0;
    endtask

    // Watchdog: the directed sequence is short, so this only fires on a hang
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b0;
        #1;

        // ---------------- reset / idle ----------------
        check_val("rst_empty",   32'(bus.empty),        32'd1);
        check_val("rst_full",    32'(bus.full),         32'd0);
        check_val("rst_count",   32'(bus.count),        32'd0);
        check_val("rst_cvalid",  32'(bus.commit_valid), 32'd0);
        check_val("rst_gnt",     32'(bus.alloc_gnt),    32'd0);
        check_val("rst_aidx",    32'(bus.alloc_idx),    32'd0);
        check_val("rst_cidx",    32'(bus.commit_idx),   32'd0);
        check_val("rst_cvalue",  32'(bus.commit_value), 32'd0);
        step();

        // ---------------- fill to full ----------------
        for (int k = 0; k < 8; k++) begin
            bus.alloc_req  = 1'b1;
            bus.alloc_func = 4'(k);
            bus.alloc_rd   = 4'(k + 1);
            #1;
            check_val("fill_gnt",  32'(bus.alloc_gnt), 32'd1);
            check_val("fill_aidx", 32'(bus.alloc_idx), 32'(k));
            step();
        end
        bus.alloc_rd = 4'd9;
        #1;
        check_val("full_flag",   32'(bus.full),      32'd1);
        check_val("full_count",  32'(bus.count),     32'd8);
        check_val("full_gnt9",   32'(bus.alloc_gnt), 32'd0);
        step();
        bus.alloc_req = 1'b0;
        #1;
        check_val("full_tail",   32'(bus.alloc_idx), 32'd0);
        check_val("full_count2", 32'(bus.count),     32'd8);

        // CDB to head: no same-cycle bypass, visible next cycle
        bus.cdb_valid = 1'b1;
        bus.cdb_idx   = 3'd0;
        bus.cdb_value = 16'h00A0;
        #1;
        check_val("nobypass_cv", 32'(bus.commit_valid), 32'd0);
        step();
        bus.cdb_valid = 1'b0;
        #1;
        check_val("head_cv",   32'(bus.commit_valid), 32'd1);
        check_val("head_val",  32'(bus.commit_value), 32'h00A0);
        check_val("head_rd",   32'(bus.commit_rd),    32'd1);

        // Full + commit + alloc request in the same cycle
        bus.alloc_req    = 1'b1;
        bus.alloc_func   = 4'd9;
        bus.alloc_rd     = 4'd9;
        bus.commit_ready = 1'b1;
        #1;
        check_val("fc_gnt",    32'(bus.alloc_gnt), 32'd0);
        step();
        bus.commit_ready = 1'b0;
        #1;
        check_val("fc_count7", 32'(bus.count),      32'd7);
        check_val("fc_cidx",   32'(bus.commit_idx), 32'd1);
        check_val("fc_gnt2",   32'(bus.alloc_gnt),  32'd1);
        check_val("fc_aidx",   32'(bus.alloc_idx),  32'd0);
        step();
        bus.alloc_req = 1'b0;
        #1;
        check_val("fc_count8", 32'(bus.count), 32'd8);
        check_val("fc_full",   32'(bus.full),  32'd1);

        // ---------------- out-of-order completion ----------------
        do_reset();
        alloc_one(4'hA, 4'd1);
        alloc_one(4'hB, 4'd2);
        alloc_one(4'hC, 4'd3);
        bus.commit_ready = 1'b1;
        bus.cdb_valid = 1'b1; bus.cdb_idx = 3'd2; bus.cdb_value = 16'h0033;
        #1;
        check_val("ooo_cv0", 32'(bus.commit_valid), 32'd0);
        step();
        bus.cdb_idx = 3'd0; bus.cdb_value = 16'h0011;
        #1;
        check_val("ooo_cv1", 32'(bus.commit_valid), 32'd0);
        check_val("ooo_cnt", 32'(bus.count),        32'd3);
        step();
        bus.cdb_idx = 3'd1; bus.cdb_value = 16'h0022;
        #1;
        check_val("ooo_c0_v",   32'(bus.commit_valid), 32'd1);
        check_val("ooo_c0_idx", 32'(bus.commit_idx),   32'd0);
        check_val("ooo_c0_val", 32'(bus.commit_value), 32'h0011);
        check_val("ooo_c0_fn",  32'(bus.commit_func),  32'hA);
        step();
        bus.cdb_valid = 1'b0;
        #1;
        check_val("ooo_c1_idx", 32'(bus.commit_idx),   32'd1);
        check_val("ooo_c1_val", 32'(bus.commit_value), 32'h0022);
        check_val("ooo_c1_rd",  32'(bus.commit_rd),    32'd2);
        step();
        #1;
        check_val("ooo_c2_idx", 32'(bus.commit_idx),   32'd2);
        check_val("ooo_c2_val", 32'(bus.commit_value), 32'h0033);
        check_val("ooo_c2_rd",  32'(bus.commit_rd),    32'd3);
        step();
        bus.commit_ready = 1'b0;
        #1;
        check_val("ooo_empty",  32'(bus.empty),        32'd1);
        check_val("ooo_cv_end", 32'(bus.commit_valid), 32'd0);
        check_val("ooo_head",   32'(bus.commit_idx),   32'd3);

        // ---------------- ignored CDB writes ----------------
        cdb_one(3'd5, 16'h5555);
        #1;
        check_val("inv_count", 32'(bus.count), 32'd0);
        check_val("inv_empty", 32'(bus.empty), 32'd1);
        check_val("inv_cv",    32'(bus.commit_valid), 32'd0);
        alloc_one(4'h7, 4'd7);               // entry 3
        cdb_one(3'd3, 16'h0777);
        cdb_one(3'd3, 16'h0999);             // duplicate, must be ignored
        // allocate entry 4 with a same-cycle CDB to it (ignored)
        bus.alloc_req = 1'b1; bus.alloc_func = 4'h8; bus.alloc_rd = 4'd8;
        bus.cdb_valid = 1'b1; bus.cdb_idx = 3'd4; bus.cdb_value = 16'h0BAD;
        step();
        bus.alloc_req = 1'b0;
        bus.cdb_valid = 1'b0;
        #1;
        check_val("dup_val",   32'(bus.commit_value), 32'h0777);
        check_val("dup_count", 32'(bus.count),        32'd2);
        bus.commit_ready = 1'b1;
        step();
        bus.commit_ready = 1'b0;
        #1;
        check_val("same_alloc_cdb_cv", 32'(bus.commit_valid), 32'd0);
        check_val("same_alloc_cidx",   32'(bus.commit_idx),   32'd4);

        // ---------------- asynchronous mid-run reset ----------------
        do_reset();
        for (int k = 0; k < 5; k++) begin
            alloc_one(4'(k), 4'(k + 1));
        end
        cdb_one(3'd0, 16'h1234);
        cdb_one(3'd1, 16'h5678);
        #1;
        check_val("pre_rst_count", 32'(bus.count),        32'd5);
        check_val("pre_rst_cv",    32'(bus.commit_valid), 32'd1);
        rst = 1'b1;                          // mid-cycle, between edges
        #1;
        check_val("arst_count",  32'(bus.count),        32'd0);
        check_val("arst_empty",  32'(bus.empty),        32'd1);
        check_val("arst_full",   32'(bus.full),         32'd0);
        check_val("arst_cv",     32'(bus.commit_valid), 32'd0);
        check_val("arst_aidx",   32'(bus.alloc_idx),    32'd0);
        check_val("arst_cidx",   32'(bus.commit_idx),   32'd0);
        check_val("arst_cval",   32'(bus.commit_value), 32'd0);
        check_val("arst_crd",    32'(bus.commit_rd),    32'd0);
        check_val("arst_gnt",    32'(bus.alloc_gnt),    32'd0);
        step();
        rst = 1'b0;
        step();

`ifdef ROB_FLUSH_EN
        // ---------------- flush ----------------
        alloc_one(4'h1, 4'd1);
        alloc_one(4'h2, 4'd2);
        flush         = 1'b1;
        bus.alloc_req = 1'b1;
        #1;
        check_val("flush_gnt", 32'(bus.alloc_gnt), 32'd0);
        step();
        flush         = 1'b0;
        bus.alloc_req = 1'b0;
        #1;
        check_val("flush_count", 32'(bus.count),     32'd0);
        check_val("flush_empty", 32'(bus.empty),     32'd1);
        check_val("flush_aidx",  32'(bus.alloc_idx), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
